// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory access over req/ack with wait states,
// branch resolution and the MEM/WB register.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_dmem_MEM,
    input  logic        write_dmem_MEM,
    input  logic [31:0] alu_result_MEM,
    input  logic [31:0] regf_rdata2_MEM,
    input  logic        write_regf_MEM,
    input  logic        mem_to_reg_MEM,
    input  logic [4:0]  waddr_regf_MEM,
    input  logic        zero_MEM,
    input  logic        is_branch_MEM,
    input  logic [31:0] pc_temp_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_err,
    output logic        write_regf_WB,
    output logic        mem_to_reg_WB,
    output logic [4:0]  waddr_regf_WB,
    output logic [31:0] alu_result_WB,
    output logic [31:0] dmem_rdata_WB
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_abort;
    logic [31:0]       r_rdata;
    logic              r_lat_wreg;
    logic              r_lat_m2r;
    logic [4:0]        r_lat_waddr;
    logic [31:0]       r_lat_alu;

    logic              w_access;
    logic              w_misaligned;
    logic              w_timeout;

    always_comb begin
        w_access     = read_dmem_MEM | write_dmem_MEM;
        w_misaligned = alu_result_MEM[1:0] != 2'b00;
        w_timeout    = r_cnt == CntW'(TIMEOUT - 1);
        mem_stall    = (r_state == StBusy) ||
                       ((r_state == StIdle) && w_access && !w_misaligned);
        pc_src        = is_branch_MEM & zero_MEM;
        branch_target = pc_temp_MEM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_abort       <= 1'b0;
            r_rdata       <= '0;
            r_lat_wreg    <= 1'b0;
            r_lat_m2r     <= 1'b0;
            r_lat_waddr   <= '0;
            r_lat_alu     <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            mem_err       <= 1'b0;
            write_regf_WB <= 1'b0;
            mem_to_reg_WB <= 1'b0;
            waddr_regf_WB <= '0;
            alu_result_WB <= '0;
            dmem_rdata_WB <= '0;
        end else begin
            mem_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_access && !w_misaligned) begin
                        r_lat_wreg  <= write_regf_MEM;
                        r_lat_m2r   <= mem_to_reg_MEM;
                        r_lat_waddr <= waddr_regf_MEM;
                        r_lat_alu   <= alu_result_MEM;
                        dmem_addr   <= alu_result_MEM;
                        dmem_wdata  <= regf_rdata2_MEM;
                        dmem_we     <= write_dmem_MEM;
                        dmem_req    <= 1'b1;
                        r_cnt       <= '0;
                        r_abort     <= 1'b0;
                        r_state     <= StBusy;
                    end else begin
                        // Misaligned accesses retire like a bubble that reports an error.
                        write_regf_WB <= write_regf_MEM & ~w_access;
                        mem_to_reg_WB <= mem_to_reg_MEM;
                        waddr_regf_WB <= waddr_regf_MEM;
                        alu_result_WB <= alu_result_MEM;
                        dmem_rdata_WB <= '0;
                        mem_err       <= w_access;
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem_ack) begin
                        r_rdata  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        r_state  <= StResp;
                    end else if (w_timeout) begin
                        r_rdata  <= '0;
                        r_abort  <= 1'b1;
                        dmem_req <= 1'b0;
                        r_state  <= StResp;
                    end
                end
                StResp: begin
                    write_regf_WB <= r_lat_wreg & ~r_abort;
                    mem_to_reg_WB <= r_lat_m2r;
                    waddr_regf_WB <= r_lat_waddr;
                    alu_result_WB <= r_lat_alu;
                    dmem_rdata_WB <= r_rdata;
                    mem_err       <= r_abort;
                    r_state       <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT = 4 and a hand-driven memory ack.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        read_dmem_MEM;
    logic        write_dmem_MEM;
    logic [31:0] alu_result_MEM;
    logic [31:0] regf_rdata2_MEM;
    logic        write_regf_MEM;
    logic        mem_to_reg_MEM;
    logic [4:0]  waddr_regf_MEM;
    logic        zero_MEM;
    logic        is_branch_MEM;
    logic [31:0] pc_temp_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        mem_err;
    logic        write_regf_WB;
    logic        mem_to_reg_WB;
    logic [4:0]  waddr_regf_WB;
    logic [31:0] alu_result_WB;
    logic [31:0] dmem_rdata_WB;

    int n_tests;
    int n_fail;

    // Per-instruction observations.
    int          n_stall;
    int          n_req;
    int          n_err;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic        q_we;
    logic        wb_wreg;
    logic        wb_m2r;
    logic [4:0]  wb_wa;
    logic [31:0] wb_alu;
    logic [31:0] wb_rdata;

    mem_access_unit #(
        .TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .read_dmem_MEM   (read_dmem_MEM),
        .write_dmem_MEM  (write_dmem_MEM),
        .alu_result_MEM  (alu_result_MEM),
        .regf_rdata2_MEM (regf_rdata2_MEM),
        .write_regf_MEM  (write_regf_MEM),
        .mem_to_reg_MEM  (mem_to_reg_MEM),
        .waddr_regf_MEM  (waddr_regf_MEM),
        .zero_MEM        (zero_MEM),
        .is_branch_MEM   (is_branch_MEM),
        .pc_temp_MEM     (pc_temp_MEM),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .mem_stall       (mem_stall),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .mem_err         (mem_err),
        .write_regf_WB   (write_regf_WB),
        .mem_to_reg_WB   (mem_to_reg_WB),
        .waddr_regf_WB   (waddr_regf_WB),
        .alu_result_WB   (alu_result_WB),
        .dmem_rdata_WB   (dmem_rdata_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_nop();
        read_dmem_MEM   = 1'b0;
        write_dmem_MEM  = 1'b0;
        alu_result_MEM  = 32'h0;
        regf_rdata2_MEM = 32'h0;
        write_regf_MEM  = 1'b0;
        mem_to_reg_MEM  = 1'b0;
        waddr_regf_MEM  = 5'd0;
        dmem_ack        = 1'b0;
    endtask

    // Presents one instruction in MEM and keeps it there until its closing edge.
    // ack_at = k acks in the k-th BUSY cycle; 0 never acks.
    task automatic do_instr(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic wreg, input logic m2r,
                            input logic [4:0] wa, input int ack_at, input logic [31:0] rdata);
        int  busy;
        bit  done;
        busy    = 0;
        done    = 1'b0;
        n_stall = 0;
        n_req   = 0;
        n_err   = 0;
        q_addr  = 32'hx;
        q_wdata = 32'hx;
        q_we    = 1'bx;
        read_dmem_MEM   = rd;
        write_dmem_MEM  = wr;
        alu_result_MEM  = addr;
        regf_rdata2_MEM = wdata;
        write_regf_MEM  = wreg;
        mem_to_reg_MEM  = m2r;
        waddr_regf_MEM  = wa;
        dmem_rdata      = rdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_stall) n_stall++;
            if (mem_err) n_err++;
            if (dmem_req) begin
                busy++;
                if (n_req == 0) begin
                    q_addr  = dmem_addr;
                    q_wdata = dmem_wdata;
                    q_we    = dmem_we;
                end
                n_req++;
            end
            dmem_ack = dmem_req && (busy == ack_at);
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("stall_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        set_nop();
        @(negedge clk);
        wb_wreg  = write_regf_WB;
        wb_m2r   = mem_to_reg_WB;
        wb_wa    = waddr_regf_WB;
        wb_alu   = alu_result_WB;
        wb_rdata = dmem_rdata_WB;
        if (mem_err) n_err++;
        @(negedge clk);
        if (mem_err) n_err++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        zero_MEM      = 1'b0;
        is_branch_MEM = 1'b0;
        pc_temp_MEM   = 32'h0;
        dmem_rdata    = 32'h0;
        set_nop();
        #12;
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_addr", dmem_addr, 32'h0);
        check_eq("rst_err", 32'(mem_err), 32'd0);
        check_eq("rst_wb_alu", alu_result_WB, 32'h0);
        check_eq("rst_wb_wreg", 32'(write_regf_WB), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU pass-through
        do_instr(1'b0, 1'b0, 32'h42, 32'h0, 1'b1, 1'b0, 5'd5, 0, 32'h0);
        check_eq("alu_stall", 32'(n_stall), 32'd0);
        check_eq("alu_req", 32'(n_req), 32'd0);
        check_eq("alu_wb_alu", wb_alu, 32'h42);
        check_eq("alu_wb_wa", 32'(wb_wa), 32'd5);
        check_eq("alu_wb_wreg", 32'(wb_wreg), 32'd1);
        check_eq("alu_wb_rdata", wb_rdata, 32'h0);

        // Load with one wait state
        do_instr(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd7, 2, 32'hDEAD_BEEF);
        check_eq("ld_stall", 32'(n_stall), 32'd3);
        check_eq("ld_req", 32'(n_req), 32'd2);
        check_eq("ld_addr", q_addr, 32'h100);
        check_eq("ld_we", 32'(q_we), 32'd0);
        check_eq("ld_wb_rdata", wb_rdata, 32'hDEAD_BEEF);
        check_eq("ld_wb_wreg", 32'(wb_wreg), 32'd1);
        check_eq("ld_wb_m2r", 32'(wb_m2r), 32'd1);
        check_eq("ld_wb_wa", 32'(wb_wa), 32'd7);
        check_eq("ld_err", 32'(n_err), 32'd0);

        // Store with immediate ack
        do_instr(1'b0, 1'b1, 32'h8, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 1, 32'h0);
        check_eq("st_stall", 32'(n_stall), 32'd2);
        check_eq("st_req", 32'(n_req), 32'd1);
        check_eq("st_we", 32'(q_we), 32'd1);
        check_eq("st_addr", q_addr, 32'h8);
        check_eq("st_wdata", q_wdata, 32'h1234_5678);
        check_eq("st_wb_wreg", 32'(wb_wreg), 32'd0);

        // Misaligned load
        do_instr(1'b1, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 5'd9, 1, 32'h5555_5555);
        check_eq("mis_req", 32'(n_req), 32'd0);
        check_eq("mis_stall", 32'(n_stall), 32'd0);
        check_eq("mis_err", 32'(n_err), 32'd1);
        check_eq("mis_wb_wreg", 32'(wb_wreg), 32'd0);
        check_eq("mis_wb_alu", wb_alu, 32'h102);

        // Timeout
        do_instr(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd3, 0, 32'hAAAA_AAAA);
        check_eq("to_req", 32'(n_req), 32'd4);
        check_eq("to_stall", 32'(n_stall), 32'd5);
        check_eq("to_err", 32'(n_err), 32'd1);
        check_eq("to_wb_wreg", 32'(wb_wreg), 32'd0);
        check_eq("to_wb_rdata", wb_rdata, 32'h0);

        do_instr(1'b0, 1'b0, 32'h77, 32'h0, 1'b1, 1'b0, 5'd12, 0, 32'h0);
        check_eq("after_to_stall", 32'(n_stall), 32'd0);
        check_eq("after_to_alu", wb_alu, 32'h77);
        check_eq("after_to_err", 32'(n_err), 32'd0);

        // Branch resolution is combinational
        is_branch_MEM = 1'b1;
        zero_MEM      = 1'b1;
        pc_temp_MEM   = 32'h40;
        #1;
        check_eq("br_pc_src", 32'(pc_src), 32'd1);
        check_eq("br_target", branch_target, 32'h40);
        zero_MEM = 1'b0;
        #1;
        check_eq("br_not_taken", 32'(pc_src), 32'd0);
        is_branch_MEM = 1'b0;

        // Reset during BUSY
        read_dmem_MEM  = 1'b1;
        alu_result_MEM = 32'h200;
        write_regf_MEM = 1'b1;
        waddr_regf_MEM = 5'd4;
        @(posedge clk);
        #1;
        check_eq("rb_req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rb_req", 32'(dmem_req), 32'd0);
        check_eq("rb_wb_alu", alu_result_WB, 32'h0);
        check_eq("rb_wb_wa", 32'(waddr_regf_WB), 32'd0);
        check_eq("rb_wb_wreg", 32'(write_regf_WB), 32'd0);
        check_eq("rb_err", 32'(mem_err), 32'd0);
        set_nop();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rb_post_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        check_eq("rb_post_err", 32'(mem_err), 32'd0);
        check_eq("rb_post_req", 32'(dmem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
